ram_delay_ctrl: RTL and testbench
=================================

Name: ram_delay_ctrl

Overview:
- Sequencing controller in front of one ram_delay instance.
- Owns the delay-length register `n`, clears the RAM on every (re)configuration, and drives the explicit write address (`addr_en` mode).
- Tracks the refill after a clear and qualifies the delay-line output with `out_valid`.
- Gates the upstream sample stream with `in_rdy` and counts samples dropped while the RAM is being cleared.

Parameters:
- P_NBITS_ADDR, 9, address width of the ram_delay RAM; legal n is 2..2^P_NBITS_ADDR-1.
- P_NBITS_DATA, 42, sample width.
- P_DEFAULT_N, 16, delay length loaded at reset.
- P_NBITS_DROP, 16, width of the dropped-sample counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cfg_n  in  P_NBITS_ADDR  requested delay length.
- cfg_req  in  1  reconfigure request; held high until cfg_ack.
- cfg_ack  out  1  one-cycle pulse: request consumed.
- cfg_err  out  1  one-cycle pulse with cfg_ack: request rejected (cfg_n<2).
- in_wr  in  1  upstream sample strobe.
- in_d  in  P_NBITS_DATA  upstream sample.
- in_rdy  out  1  sample accepted when in_wr&&in_rdy.
- rd_wr  out  1  to ram_delay wr.
- rd_d  out  P_NBITS_DATA  to ram_delay d.
- rd_n  out  P_NBITS_ADDR  to ram_delay n.
- rd_flush  out  1  to ram_delay flush.
- rd_addr_en  out  1  to ram_delay addr_en; constant 1 after reset.
- rd_addr  out  P_NBITS_ADDR  to ram_delay addr.
- out_valid  out  1  ram_delay qo is a true n-sample-delayed value.
- busy  out  1  high in S_FLUSH.
- drop_cnt  out  P_NBITS_DROP  saturating count of samples refused.

Behaviour:
- **Reset** (rst high at posedge), registered:
  - state=S_FLUSH, cnt=0, rd_n=P_DEFAULT_N, rd_addr=0.
  - rd_wr=0, rd_flush=0, rd_d=0, rd_addr_en=0.
  - cfg_ack=0, cfg_err=0, out_valid=0, drop_cnt=0.
  - in_rdy=0 while rst.
  - rst mid-operation aborts any state and restarts the clear with P_DEFAULT_N; a pending cfg_req is not acked.
- **Output timing:** all rd_* outputs are registered. An accepted sample appears on rd_wr/rd_d exactly 1 cycle after acceptance. in_rdy is combinational: !rst && state!=S_FLUSH.
- **Address counter `wa`** (drives rd_addr):
  - In S_FILL/S_RUN, advances by 1 on each accepted write.
  - Wraps from rd_n-1 to 0.
  - rd_addr carries the address of the write presented on the same cycle's rd_wr.
- **States:**
  - **S_FLUSH:**
    - Each cycle issues rd_wr=1, rd_flush=1, rd_d=0, rd_addr=cnt; cnt counts 0..rd_n-1.
    - Lasts exactly rd_n cycles, then goes to S_FILL with cnt=0 and wa=0.
    - busy=1, out_valid=0.
    - in_wr arriving here is dropped and increments drop_cnt (saturates at all-ones).
  - **S_FILL:**
    - Forwards accepted writes with rd_flush=0; cnt counts accepted writes.
    - When cnt reaches rd_n-1 and a write is accepted, goes to S_RUN.
    - out_valid=0.
  - **S_RUN:**
    - Forwards writes; out_valid=1 registered, rising with the rd_wr of the (rd_n+1)-th post-clear sample.
    - At that point qo = sample written rd_n writes earlier.
- **Config handshake** (only in S_FILL/S_RUN; cfg_req is ignored in S_FLUSH and remains pending):
  - cfg_req && cfg_n>=2: latch rd_n<=cfg_n, pulse cfg_ack, go S_FLUSH next cycle with cnt=0, out_valid drops next cycle.
  - cfg_req && cfg_n<2: pulse cfg_ack and cfg_err; no state or n change.
  - Simultaneous in_wr and an accepted cfg_req: the write is accepted and forwarded under the old n (at the old wa), then the flush begins.
  - cfg_req with cfg_n equal to current rd_n still performs a full clear.
- **Widths:** counters and wa are P_NBITS_ADDR bits. The compare against rd_n-1 uses the registered rd_n, never cfg_n.

Test Plan:
- **Reset default clear:** rst 10 cycles, release -> 16 cycles of rd_wr=1, rd_flush=1, rd_d=0, rd_addr 0..15; busy=1 throughout; in_rdy=0; then in_rdy=1, busy=0.
- **Fill then run:** 40 back-to-back writes d=1..40 after the clear -> rd_addr sequence 0..15,0..15,0..7; out_valid first high with d=17; while valid, qo+16==qn.
- **Bursty input:** 20 writes each followed by 1–4 idle cycles -> wa advances only on writes; out_valid rises on the 17th write; qo+16==qn whenever valid.
- **Reconfigure in run:** cfg_n=32 with cfg_req while in_wr=1 -> that write is forwarded with n=16; cfg_ack pulses once; 32 flush cycles follow; in_wr during them -> drop_cnt +1 per cycle; after 32 further writes out_valid=1 and qo+32==qn.
- **Bad config:** cfg_n=1 -> cfg_ack and cfg_err pulse together; rd_n stays 16; out_valid is unchanged.
- **Hold and abort:** cfg_req asserted during S_FLUSH -> acked only on the first S_FILL cycle. Reset asserted mid-fill -> rd_n=16; the clear restarts at addr 0; drop_cnt=0.

Source files
------------

// File: rtl/ram_delay_ctrl.sv
// Sequencing controller for a ram_delay instance: clears the RAM on (re)configuration,
// drives explicit write addresses, tracks the refill and qualifies the delayed output.
module ram_delay_ctrl #(
    parameter int P_NBITS_ADDR = 9,
    parameter int P_NBITS_DATA = 42,
    parameter int P_DEFAULT_N  = 16,
    parameter int P_NBITS_DROP = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [P_NBITS_ADDR-1:0] cfg_n,
    input  logic                    cfg_req,
    output logic                    cfg_ack,
    output logic                    cfg_err,
    input  logic                    in_wr,
    input  logic [P_NBITS_DATA-1:0] in_d,
    output logic                    in_rdy,
    output logic                    rd_wr,
    output logic [P_NBITS_DATA-1:0] rd_d,
    output logic [P_NBITS_ADDR-1:0] rd_n,
    output logic                    rd_flush,
    output logic                    rd_addr_en,
    output logic [P_NBITS_ADDR-1:0] rd_addr,
    output logic                    out_valid,
    output logic                    busy,
    output logic [P_NBITS_DROP-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        S_FLUSH = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam logic [P_NBITS_ADDR-1:0] ADDR_ONE  = P_NBITS_ADDR'(1);
    localparam logic [P_NBITS_ADDR-1:0] ADDR_TWO  = P_NBITS_ADDR'(2);
    localparam logic [P_NBITS_ADDR-1:0] DEFAULT_N = P_NBITS_ADDR'(P_DEFAULT_N);
    localparam logic [P_NBITS_DROP-1:0] DROP_ONE  = P_NBITS_DROP'(1);
    localparam logic [P_NBITS_DROP-1:0] DROP_MAX  = {P_NBITS_DROP{1'b1}};

    state_t                  state_r;
    state_t                  state_s;
    logic [P_NBITS_ADDR-1:0] cnt_r;
    logic [P_NBITS_ADDR-1:0] cnt_s;
    logic [P_NBITS_ADDR-1:0] wa_r;
    logic [P_NBITS_ADDR-1:0] wa_s;
    logic [P_NBITS_ADDR-1:0] n_s;
    logic [P_NBITS_ADDR-1:0] n_last_s;
    logic [P_NBITS_ADDR-1:0] addr_s;
    logic [P_NBITS_DATA-1:0] d_s;
    logic [P_NBITS_DROP-1:0] drop_s;
    logic                    wr_s;
    logic                    flush_s;
    logic                    ack_s;
    logic                    err_s;
    logic                    valid_s;
    logic                    accept_s;
    logic                    cfg_take_s;

    // Wrap point always comes from the registered length, never from cfg_n.
    assign n_last_s   = rd_n - ADDR_ONE;
    assign in_rdy     = !rst && (state_r != S_FLUSH);
    assign busy       = (state_r == S_FLUSH);
    assign accept_s   = in_wr && in_rdy;
    // A request is held until acked; the ack cycle itself must not consume it again.
    assign cfg_take_s = cfg_req && !cfg_ack && (state_r != S_FLUSH);

    // Next-state and next-output logic for the clear / fill / run sequence.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        wa_s    = wa_r;
        n_s     = rd_n;
        wr_s    = 1'b0;
        flush_s = 1'b0;
        d_s     = rd_d;
        addr_s  = rd_addr;
        ack_s   = 1'b0;
        err_s   = 1'b0;
        valid_s = out_valid;
        drop_s  = drop_cnt;
        case (state_r)
            S_FLUSH: begin
                wr_s    = 1'b1;
                flush_s = 1'b1;
                d_s     = '0;
                addr_s  = cnt_r;
                valid_s = 1'b0;
                if (in_wr && (drop_cnt != DROP_MAX)) begin
                    drop_s = drop_cnt + DROP_ONE;
                end else begin
                    drop_s = drop_cnt;
                end
                if (cnt_r == n_last_s) begin
                    state_s = S_FILL;
                    cnt_s   = '0;
                    wa_s    = '0;
                end else begin
                    cnt_s = cnt_r + ADDR_ONE;
                end
            end
            S_FILL, S_RUN: begin
                if (accept_s) begin
                    wr_s   = 1'b1;
                    d_s    = in_d;
                    addr_s = wa_r;
                    if (wa_r == n_last_s) begin
                        wa_s = '0;
                    end else begin
                        wa_s = wa_r + ADDR_ONE;
                    end
                    if (state_r == S_RUN) begin
                        valid_s = 1'b1;
                    end else if (cnt_r == n_last_s) begin
                        state_s = S_RUN;
                        cnt_s   = '0;
                    end else begin
                        cnt_s = cnt_r + ADDR_ONE;
                    end
                end else begin
                    wr_s = 1'b0;
                end
                // A same-cycle write above still lands under the old length.
                if (cfg_take_s) begin
                    ack_s = 1'b1;
                    if (cfg_n < ADDR_TWO) begin
                        err_s = 1'b1;
                    end else begin
                        n_s     = cfg_n;
                        state_s = S_FLUSH;
                        cnt_s   = '0;
                        valid_s = 1'b0;
                    end
                end else begin
                    ack_s = 1'b0;
                end
            end
            default: begin
                state_s = S_FLUSH;
                cnt_s   = '0;
                wa_s    = '0;
                valid_s = 1'b0;
            end
        endcase
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_FLUSH;
            cnt_r      <= '0;
            wa_r       <= '0;
            rd_n       <= DEFAULT_N;
            rd_addr    <= '0;
            rd_wr      <= 1'b0;
            rd_flush   <= 1'b0;
            rd_d       <= '0;
            rd_addr_en <= 1'b0;
            cfg_ack    <= 1'b0;
            cfg_err    <= 1'b0;
            out_valid  <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            wa_r       <= wa_s;
            rd_n       <= n_s;
            rd_addr    <= addr_s;
            rd_wr      <= wr_s;
            rd_flush   <= flush_s;
            rd_d       <= d_s;
            rd_addr_en <= 1'b1;
            cfg_ack    <= ack_s;
            cfg_err    <= err_s;
            out_valid  <= valid_s;
            drop_cnt   <= drop_s;
        end
    end

endmodule

// File: tb/tb_ram_delay_ctrl.sv
// Bench for ram_delay_ctrl: a sample-count model predicts every output each cycle,
// and a shadow RAM checks that valid writes see the value written n writes earlier.
module tb_ram_delay_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  cfg_n;
    logic        cfg_req;
    logic        cfg_ack;
    logic        cfg_err;
    logic        in_wr;
    logic [41:0] in_d;
    logic        in_rdy;
    logic        rd_wr;
    logic [41:0] rd_d;
    logic [8:0]  rd_n;
    logic        rd_flush;
    logic        rd_addr_en;
    logic [8:0]  rd_addr;
    logic        out_valid;
    logic        busy;
    logic [15:0] drop_cnt;

    ram_delay_ctrl #(
        .P_NBITS_ADDR(9), .P_NBITS_DATA(42), .P_DEFAULT_N(16), .P_NBITS_DROP(16)
    ) dut (
        .clk(clk), .rst(rst), .cfg_n(cfg_n), .cfg_req(cfg_req), .cfg_ack(cfg_ack),
        .cfg_err(cfg_err), .in_wr(in_wr), .in_d(in_d), .in_rdy(in_rdy), .rd_wr(rd_wr),
        .rd_d(rd_d), .rd_n(rd_n), .rd_flush(rd_flush), .rd_addr_en(rd_addr_en),
        .rd_addr(rd_addr), .out_valid(out_valid), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: flush_left cycles of clearing remain; wc counts writes since the last clear.
    bit          m_started = 1'b0;
    bit          m_rst;
    int          m_n, m_left, m_idx, m_wc, m_drop;
    bit          e_wr, e_fl, e_ack, e_err, e_valid, e_aen;
    logic [41:0] e_d;
    logic [8:0]  e_addr;

    always @(posedge clk) begin
        if (rst) begin
            m_started = 1'b1; m_rst = 1'b1;
            m_n = 16; m_left = 16; m_idx = 0; m_wc = 0; m_drop = 0;
            e_wr = 0; e_fl = 0; e_d = '0; e_addr = '0; e_ack = 0; e_err = 0; e_valid = 0; e_aen = 0;
        end else if (m_started) begin
            m_rst = 1'b0; e_aen = 1; e_ack = 0; e_err = 0; e_wr = 0; e_fl = 0;
            if (m_left > 0) begin
                e_wr = 1; e_fl = 1; e_d = '0; e_addr = 9'(m_idx);
                m_idx++; m_left--; e_valid = 0;
                if (in_wr && m_drop != 65535) m_drop++;
            end else begin
                if (in_wr) begin
                    e_wr = 1; e_d = in_d; e_addr = 9'(m_wc % m_n);
                    m_wc++;
                    e_valid = (m_wc > m_n);
                end
                if (cfg_req) begin
                    e_ack = 1;
                    if (cfg_n < 9'd2) e_err = 1;
                    else begin
                        m_n = int'(cfg_n); m_left = int'(cfg_n); m_idx = 0; m_wc = 0; e_valid = 0;
                    end
                end
            end
        end
    end

    logic [41:0] ram [0:511];
    int          flush_seen = 0;
    int          ack_cnt = 0;
    int          err_cnt = 0;
    logic [41:0] rise_d = '0;
    logic        prev_valid = 1'b0;

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_started) begin
            chk("in_rdy", in_rdy, !rst && m_left == 0);
            chk("busy", busy, m_left > 0);
            chk("rd_wr", rd_wr, e_wr);
            chk("rd_n", rd_n, 9'(m_n));
            chk("rd_addr_en", rd_addr_en, e_aen);
            chk("cfg_ack", cfg_ack, e_ack);
            chk("cfg_err", cfg_err, e_err);
            chk("out_valid", out_valid, e_valid);
            chk("drop_cnt", drop_cnt, 16'(m_drop));
            if (e_wr) begin
                chk("rd_flush", rd_flush, e_fl);
                chk("rd_d", rd_d, e_d);
                chk("rd_addr", rd_addr, e_addr);
                if (e_valid && !e_fl) chk("delay_qo", 64'(ram[rd_addr]) + 64'(m_n), rd_d);
                ram[rd_addr] = rd_d;
            end
            if (m_rst) begin
                chk("rst_addr", rd_addr, 0);
                chk("rst_d", rd_d, 0);
                chk("rst_flush", rd_flush, 0);
            end
            if (rd_wr === 1'b1 && rd_flush === 1'b1) flush_seen++;
            if (cfg_ack === 1'b1) ack_cnt++;
            if (cfg_ack === 1'b1 && cfg_err === 1'b1) err_cnt++;
            if (out_valid === 1'b1 && prev_valid !== 1'b1 && rd_wr === 1'b1) rise_d = rd_d;
            prev_valid = out_valid;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [8:0] n, output int waited);
        bit done = 0;
        cfg_n = n; cfg_req = 1'b1; waited = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            tick;
            waited++;
            if (cfg_ack === 1'b1) done = 1;
        end
        if (!done) chk("cfg_ack_timeout", 0, 1);
        cfg_req = 1'b0;
    endtask

    initial begin
        int          w;
        int          a0, e0;
        bit          acc;
        logic [41:0] d;
        rst = 1'b1; in_wr = 1'b0; in_d = '0; cfg_req = 1'b0; cfg_n = '0;
        repeat (10) tick;
        rst = 1'b0;
        repeat (20) tick;
        chk("flush_count", flush_seen, 16);
        chk("rdy_after_clear", in_rdy, 1);
        chk("drop_after_clear", drop_cnt, 0);

        // Back-to-back fill and run.
        for (int i = 1; i <= 40; i++) begin
            in_wr = 1'b1; in_d = 42'(i); tick;
        end
        in_wr = 1'b0;
        repeat (3) tick;
        chk("first_valid_d", rise_d, 17);

        // Same length still clears fully, then bursty writes.
        do_cfg(9'd16, w);
        repeat (20) tick;
        d = 42'd41;
        for (int i = 0; i < 20; i++) begin
            in_wr = 1'b1; in_d = d; d++; tick;
            in_wr = 1'b0; repeat (i % 4 + 1) tick;
        end
        chk("bursty_valid_d", rise_d, 57);

        // Reconfigure to 32 with a simultaneous write, writes held during the clear.
        a0 = ack_cnt; e0 = int'(drop_cnt);
        in_wr = 1'b1; in_d = 42'd61; cfg_n = 9'd32; cfg_req = 1'b1;
        tick;
        cfg_req = 1'b0;
        chk("reconfig_ack", cfg_ack, 1);
        d = 42'd62;
        for (int k = 0; k < 80; k++) begin
            in_wr = 1'b1; in_d = d; acc = in_rdy; tick;
            if (acc) d++;
        end
        in_wr = 1'b0; tick;
        chk("reconfig_drops", int'(drop_cnt) - e0, 32);
        chk("reconfig_n", rd_n, 32);
        chk("reconfig_ack_once", ack_cnt - a0, 1);
        chk("reconfig_valid_d", rise_d, 94);

        // Rejected length.
        e0 = err_cnt;
        do_cfg(9'd1, w);
        chk("bad_err", cfg_err, 1);
        tick;
        chk("bad_err_count", err_cnt - e0, 1);
        chk("bad_n", rd_n, 32);
        chk("bad_valid", out_valid, 1);

        // Request during a clear waits for the first fill cycle.
        do_cfg(9'd16, w);
        do_cfg(9'd20, w);
        chk("hold_wait", w, 17);
        chk("hold_n", rd_n, 20);
        repeat (24) tick;
        for (int i = 0; i < 5; i++) begin
            in_wr = 1'b1; in_d = 42'(200 + i); tick;
        end
        in_wr = 1'b0;

        // Reset mid-fill restarts the default clear.
        rst = 1'b1; tick; tick;
        rst = 1'b0;
        chk("abort_drop", drop_cnt, 0);
        chk("abort_n", rd_n, 16);
        chk("abort_busy", busy, 1);
        tick;
        chk("abort_addr", rd_addr, 0);
        chk("abort_flush", rd_flush, 1);
        repeat (20) tick;
        chk("abort_ready", in_rdy, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
